// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx: 8N1 UART receiver, LSB first, one bit per CLKS_PER_BIT clocks.
// Synchronises the asynchronous serial line, qualifies the start bit at
// mid-bit, shifts in eight data bits and checks the stop bit.
//
// Parameters:
//   CLKS_PER_BIT  clocks per bit period; even and >= 8 (default 16)
//
// Ports:
//   i_clk        system clock, all logic on the rising edge
//   i_reset      asynchronous active-high reset
//   i_rxd        serial line, asynchronous to i_clk, idle high
//   o_data       last correctly framed byte, held until the next good frame
//   o_valid      one-cycle pulse when o_data is updated
//   o_frame_err  one-cycle pulse when the stop bit samples low
//   o_busy       high whenever the receiver is not idle
//
// Build option:
//   UART_RX_MAJORITY_EN  when defined, each bit decision is a 2-of-3 vote of
//                        the synchronised line at cnt = k-2, k-1 and k.
// -----------------------------------------------------------------------------
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_rxd,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_frame_err,
    output logic       o_busy
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic             sync1;
    logic             sync2;
    logic             prev;
    logic             sample;

    // Two-flop synchroniser plus previous-value flop for falling-edge detect.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            prev  <= 1'b1;
        end else begin
            sync1 <= i_rxd;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic vote1;
    logic vote2;

    // Free-running history: at cnt = k, vote1/vote2 hold sync2 from k-1/k-2.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            vote1 <= 1'b1;
            vote2 <= 1'b1;
        end else begin
            vote1 <= sync2;
            vote2 <= vote1;
        end
    end

    assign sample = (vote1 & vote2) | (vote1 & sync2) | (vote2 & sync2);
`else
    assign sample = sync2;
`endif

    // Receive FSM with registered outputs.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state       <= IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            o_data      <= 8'h00;
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
            o_busy      <= 1'b0;
        end else begin
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    // prev tracks sync2 continuously, so a held-low line cannot re-arm.
                    if (!sync2 && prev) begin
                        state  <= START;
                        o_busy <= 1'b1;
                    end
                end
                START: begin
                    if (cnt == HALF_LAST) begin
                        cnt <= '0;
                        if (!sample) begin
                            state   <= DATA;
                            bit_idx <= 3'd0;
                        end else begin
                            state  <= IDLE;
                            o_busy <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt     <= '0;
                        // Right shift: first (LSB) bit ends up in bit 0 after eight samples.
                        shreg   <= {sample, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (cnt == BIT_LAST) begin
                        // Leaving at stop-bit centre leaves half a bit to catch the next start edge.
                        cnt    <= '0;
                        state  <= IDLE;
                        o_busy <= 1'b0;
                        if (sample) begin
                            o_data  <= shreg;
                            o_valid <= 1'b1;
                        end else begin
                            o_frame_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state  <= IDLE;
                    cnt    <= '0;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver paired with the board's `uart_tx` transmitter: it consumes the serial line that `uart_tx` drives and recovers 8N1 frames, LSB first, at one bit per `CLKS_PER_BIT` clocks. It synchronises the asynchronous line, qualifies start bits at mid-bit, shifts in eight data bits and checks the stop bit. Each received byte is presented on a parallel bus with a one-cycle valid strobe, for use by the board logic (LEDs/registers) or a loopback checker.

## Interface
- `CLKS_PER_BIT`, default 16: clocks per bit; must be even and ≥ 8; matches the divide-by-16 bit period of `uart_tx`.
- `i_clk`  input  1  system clock; one clock domain, all logic on its rising edge.
- `i_reset`  input  1  asynchronous, active-high reset.
- `i_rxd`  input  1  serial line, asynchronous to `i_clk`; idle high.
- `o_data`  output  8  last correctly framed byte; holds its value until the next good frame.
- `o_valid`  output  1  one-cycle pulse when `o_data` is updated.
- `o_frame_err`  output  1  one-cycle pulse when the stop bit samples low.
- `o_busy`  output  1  high whenever the FSM is not IDLE.

## Operation
- **Synchroniser**
  - `i_rxd` passes through two flops: sync1, then sync2.
  - A third flop `prev` holds the previous sync2 value.
  - All three reset to 1.
- **Counter:** `cnt` is $clog2(CLKS_PER_BIT) bits wide. It clears on every state transition and otherwise increments by 1 in non-IDLE states.
- **Bit index:** `bit_idx` is 3 bits wide and counts data bits 0..7.
- **FSM states:** IDLE, START, DATA, STOP.
  - **IDLE:** on a falling edge (sync2 = 0 and `prev` = 1), go to START.
  - **START:** at `cnt` = `CLKS_PER_BIT`/2 − 1, sample the line.
    - Sample 0: go to DATA with `bit_idx` = 0.
    - Sample 1: the start was a glitch; go back to IDLE with no outputs.
  - **DATA:** at `cnt` = `CLKS_PER_BIT` − 1, sample the line.
    - Shift the sample into bit 7 of the shift register; the register shifts right, so LSB-first order is restored.
    - `bit_idx` increments. After bit 7 is sampled, go to STOP.
  - **STOP:** at `cnt` = `CLKS_PER_BIT` − 1, sample the line.
    - Sample 1: `o_data` ← shift register, `o_valid` = 1 for one cycle.
    - Sample 0: `o_frame_err` = 1 for one cycle; `o_data` keeps its value.
    - In both cases, go to IDLE.
- **After a framing error:** IDLE re-arms only on a new falling edge. A line held low (break) therefore produces exactly one `o_frame_err` and nothing more until the line returns high and falls again.
- **Back-to-back frames:** a start edge that arrives during the remaining half stop bit is detected normally, because IDLE is re-entered at stop-bit centre.
- **Outputs:** `o_valid` and `o_frame_err` are registered and never both high.
- **Reset:**
  - Asserting `i_reset` at any time, including mid-frame, forces: state = IDLE, `cnt` = 0, `bit_idx` = 0, shift register = 0.
  - Output reset values: `o_data` = 8'h00, `o_valid` = 0, `o_frame_err` = 0, `o_busy` = 0.
  - A partial frame is discarded with no pulse.

## Timing
- **Cycle reference:** cycle 0 is the first rising edge at which `i_rxd` = 0 is captured into sync1.
- **Start detection:** START is entered at cycle 2.
- **Sample points** (H = `CLKS_PER_BIT`/2, C = `CLKS_PER_BIT`):
  - Start bit: sampled at cycle 1 + H.
  - Data bit n (n = 0..7): sampled at cycle 1 + H + (n+1)·C.
  - Stop bit: sampled at cycle 1 + H + 9·C.
- **Result pulse:** `o_valid` or `o_frame_err` is high during cycle 2 + H + 9·C. With the default C = 16 this is cycle 154.
- **`o_busy`:** rises at cycle 2 and falls in the same cycle as the result pulse. It also falls 1 + H cycles after the start edge on a rejected glitch.
- **Input width:** a low pulse shorter than H − 1 clocks never produces `o_valid`.
- **Rate tolerance:** at least ±3% mismatch between transmitter and receiver bit rate is tolerated with C = 16.

## Configuration
- **Macro:** `UART_RX_MAJORITY_EN`.
- **Defined:** every sample point (start, data, stop) uses a 2-of-3 majority vote instead of a single sample.
  - The votes are sync2 at `cnt` = k−2, k−1 and k, where k is the nominal sample count.
  - Two extra vote flops are added; decision timing is unchanged.
  - A single-clock glitch at a sample point is rejected.
- **Undefined:** each decision is the single sync2 value at `cnt` = k.
- **Common to both builds:** the FSM and all latencies are identical.

## Test plan
- **Single frame:** drive byte 8'hA5 as 8N1 at 16 clocks/bit → one `o_valid` pulse at cycle 154 with `o_data` = 8'hA5; `o_frame_err` stays 0; `o_busy` is high from cycle 2 to cycle 154.
- **Back-to-back frames:** send 8'h00, then 8'hFF, then 8'h3C with no idle time between frames → three `o_valid` pulses, spaced 160 cycles apart, carrying 00, FF and 3C in order.
- **Glitch rejection:** a 4-clock low pulse on an idle line → no `o_valid`, no `o_frame_err`; `o_busy` falls back to 0 within 10 cycles.
- **Framing error:** send 8'h55 with the stop bit driven 0, then hold the line low for 40 bit periods → exactly one `o_frame_err`, `o_data` keeps its previous value, and the next good 8'h12 frame is received correctly.
- **Reset mid-frame:** pulse `i_reset` after bit 3 of 8'hC3 → all outputs return to their reset values immediately; no pulse for the partial frame; a following 8'h81 frame is received correctly.
- **`UART_RX_MAJORITY_EN` defined:** a 1-clock high glitch at the centre of data bit 2 of 8'h00 → `o_data` = 8'h00. With the macro undefined, the same stimulus → `o_data` = 8'h04.
